// File: rtl/alu_sequencer_pkg.sv
// Shared ALU function codes, sequencer opcodes and flag bit positions.
// The flag index macros are shared by every block that decodes the ALU flags.
`ifndef FLAGS_Z
`define FLAGS_Z 3
`define FLAGS_N 2
`define FLAGS_C 1
`define FLAGS_V 0
`endif

package opcodes;

    typedef enum logic [3:0] {
        FnNOP  = 4'd0,
        FnADD  = 4'd1,
        FnSUB  = 4'd2,
        FnAND  = 4'd3,
        FnOR   = 4'd4,
        FnXOR  = 4'd5,
        FnNOT  = 4'd6,
        FnLSL  = 4'd7,
        FnLSR  = 4'd8,
        FnASR  = 4'd9,
        FnPASS = 4'd10
    } alu_functions_t;

    typedef enum logic [1:0] {
        SEQ_SHL = 2'd0,
        SEQ_SHR = 2'd1,
        SEQ_MUL = 2'd2,
        SEQ_RSV = 2'd3
    } seq_op_t;

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle shift / multiply controller that borrows the shared ALU one operation per cycle.
// The parent muxes the ALU inputs from this block while Busy is high.
module alu_sequencer
    import opcodes::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Start,
    input  seq_op_t        SeqOp,
    input  logic [15:0]    A,
    input  logic [15:0]    B,
    output logic           Busy,
    output logic           Done,
    output logic [15:0]    Result,
    output logic [3:0]     Flags,
    output alu_functions_t AluOp,
    output logic [15:0]    AluOp1,
    output logic [15:0]    AluOp2,
    output logic           AluCarryIn,
    input  logic [15:0]    AluResult,
    input  logic [3:0]     AluFlags
);

    typedef enum logic [2:0] {StIdle, StShift, StMulAdd, StMulShift, StFin} state_e;

    state_e      state_q, state_d;
    seq_op_t     op_q, op_d;
    logic [15:0] work_q, work_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  iter_q, iter_d;
    logic [3:0]  flags_q, flags_d;
    logic        csticky_q, csticky_d;
    logic        cshift_q, cshift_d;
    logic        done_q, done_d;
    logic [15:0] fin_res;
    logic        fin_c;
    logic        unused_alu_flags;

    assign unused_alu_flags = ^{AluFlags[`FLAGS_Z], AluFlags[`FLAGS_N], AluFlags[`FLAGS_V]};

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        work_d     = work_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        result_d   = result_q;
        cnt_d      = cnt_q;
        iter_d     = iter_q;
        flags_d    = flags_q;
        csticky_d  = csticky_q;
        cshift_d   = cshift_q;
        done_d     = 1'b0;
        AluOp      = FnNOP;
        AluOp1     = 16'd0;
        AluOp2     = 16'd0;
        fin_res    = 16'd0;
        fin_c      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    op_d      = SeqOp;
                    work_d    = A;
                    mcand_d   = A;
                    mplier_d  = B;
                    cnt_d     = B[3:0];
                    acc_d     = 16'd0;
                    iter_d    = 4'd0;
                    csticky_d = 1'b0;
                    cshift_d  = 1'b0;
                    unique case (SeqOp)
                        SEQ_SHL, SEQ_SHR: state_d = (B[3:0] == 4'd0) ? StFin : StShift;
                        SEQ_MUL: begin
                            if (B == 16'd0) state_d = StFin;
                            else            state_d = B[0] ? StMulAdd : StMulShift;
                        end
                        default: state_d = StFin;
                    endcase
                end
            end
            StShift: begin
                AluOp    = (op_q == SEQ_SHL) ? FnLSL : FnLSR;
                AluOp1   = work_q;
                work_d   = AluResult;
                cnt_d    = cnt_q - 4'd1;
                cshift_d = (op_q == SEQ_SHL) ? work_q[15] : work_q[0];
                if (cnt_q == 4'd1) state_d = StFin;
            end
            StMulAdd: begin
                AluOp     = FnADD;
                AluOp1    = acc_q;
                AluOp2    = mcand_q;
                acc_d     = AluResult;
                csticky_d = csticky_q | AluFlags[`FLAGS_C];
                state_d   = StMulShift;
            end
            StMulShift: begin
                AluOp    = FnLSL;
                AluOp1   = mcand_q;
                mcand_d  = AluResult;
                mplier_d = mplier_q >> 1;
                iter_d   = iter_q + 4'd1;
                // iter_q counts completed iterations; 15 here means this is the 16th.
                if ((EARLY_EXIT && (mplier_d == 16'd0)) || (iter_q == 4'd15)) state_d = StFin;
                else state_d = mplier_d[0] ? StMulAdd : StMulShift;
            end
            StFin: begin
                unique case (op_q)
                    SEQ_SHL, SEQ_SHR: begin fin_res = work_q; fin_c = cshift_q;  end
                    SEQ_MUL:          begin fin_res = acc_q;  fin_c = csticky_q; end
                    default:          begin fin_res = 16'd0;  fin_c = 1'b0;      end
                endcase
                result_d            = fin_res;
                flags_d             = 4'd0;
                flags_d[`FLAGS_Z]   = (fin_res == 16'd0);
                flags_d[`FLAGS_N]   = fin_res[15];
                flags_d[`FLAGS_C]   = fin_c;
                done_d              = 1'b1;
                state_d             = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            op_q      <= SEQ_SHL;
            work_q    <= 16'd0;
            mcand_q   <= 16'd0;
            mplier_q  <= 16'd0;
            acc_q     <= 16'd0;
            result_q  <= 16'd0;
            cnt_q     <= 4'd0;
            iter_q    <= 4'd0;
            flags_q   <= 4'd0;
            csticky_q <= 1'b0;
            cshift_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            work_q    <= work_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            iter_q    <= iter_d;
            flags_q   <= flags_d;
            csticky_q <= csticky_d;
            cshift_q  <= cshift_d;
            done_q    <= done_d;
        end
    end

    assign Busy       = (state_q != StIdle);
    assign Done       = done_q;
    assign Result     = result_q;
    assign Flags      = flags_q;
    assign AluCarryIn = 1'b0;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (early exit on / off) share stimulus, each with its own ALU
// and an operation-level reference model checked every cycle.
module tb_alu_sequencer;
    import opcodes::*;

    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FC = 1;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] o1;
        logic [15:0] o2;
    } step_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    seq_op_t     SeqOp;
    logic [15:0] A;
    logic [15:0] B;

    logic [1:0]       busy, done, cin;
    logic [1:0][15:0] result, op1, op2;
    logic [1:0][3:0]  flags, alu_op;

    int checks = 0;
    int errors = 0;

    step_t       steps [2][40];
    int          m_len [2];
    int          m_pos [2];
    bit          m_busy[2] = '{0, 0};
    bit          m_done[2] = '{0, 0};
    logic [15:0] m_res [2];
    logic [3:0]  m_flg [2];
    logic [15:0] e_res [2];
    logic [3:0]  e_flg [2];
    bit          armed = 0;

    always #5 Clock = ~Clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic           l_busy, l_done, l_cin, ac;
        logic [15:0]    l_res, l_o1, l_o2, ares;
        logic [3:0]     l_flg, aflg;
        logic [16:0]    s17;
        alu_functions_t l_op;

        alu_sequencer #(.EARLY_EXIT(g == 0)) u_dut (
            .Clock      (Clock),
            .Reset      (Reset),
            .Start      (Start),
            .SeqOp      (SeqOp),
            .A          (A),
            .B          (B),
            .Busy       (l_busy),
            .Done       (l_done),
            .Result     (l_res),
            .Flags      (l_flg),
            .AluOp      (l_op),
            .AluOp1     (l_o1),
            .AluOp2     (l_o2),
            .AluCarryIn (l_cin),
            .AluResult  (ares),
            .AluFlags   (aflg)
        );

        // Parent-side ALU: only the functions the sequencer uses are modelled.
        always_comb begin
            s17  = 17'd0;
            ares = 16'd0;
            ac   = 1'b0;
            case (l_op)
                FnADD: begin
                    s17  = {1'b0, l_o1} + {1'b0, l_o2} + {16'd0, l_cin};
                    ares = s17[15:0];
                    ac   = s17[16];
                end
                FnLSL: begin ares = {l_o1[14:0], 1'b0}; ac = l_o1[15]; end
                FnLSR: begin ares = {1'b0, l_o1[15:1]}; ac = l_o1[0];  end
                default: ;
            endcase
            aflg     = 4'd0;
            aflg[FZ] = (ares == 16'd0);
            aflg[FN] = ares[15];
            aflg[FC] = ac;
        end

        assign busy[g]   = l_busy;
        assign done[g]   = l_done;
        assign cin[g]    = l_cin;
        assign result[g] = l_res;
        assign flags[g]  = l_flg;
        assign op1[g]    = l_o1;
        assign op2[g]    = l_o2;
        assign alu_op[g] = l_op;
    end

    task automatic check(input string nm, input int g, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 30) $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, g, $time, act, exp);
        end
    endtask

    task automatic push(input int g, inout int n, input alu_functions_t op,
                        input logic [15:0] o1, input logic [15:0] o2);
        steps[g][n].op = op;
        steps[g][n].o1 = o1;
        steps[g][n].o2 = o2;
        n++;
    endtask

    // Expected ALU op list, result and flags of one whole operation.
    task automatic build(input int g, input seq_op_t op, input logic [15:0] a,
                         input logic [15:0] b);
        int          n = 0;
        int          last = -1;
        logic [15:0] w = a;
        logic [15:0] acc = 16'd0;
        logic [15:0] mc = a;
        logic [16:0] s;
        logic [31:0] prod;
        logic [15:0] res = 16'd0;
        logic        c = 1'b0;
        case (op)
            SEQ_SHL, SEQ_SHR: begin
                for (int i = 0; i < int'(b[3:0]); i++) begin
                    push(g, n, (op == SEQ_SHL) ? FnLSL : FnLSR, w, 16'd0);
                    c = (op == SEQ_SHL) ? w[15] : w[0];
                    w = (op == SEQ_SHL) ? (w << 1) : (w >> 1);
                end
                res = w;
            end
            SEQ_MUL: begin
                for (int i = 0; i < 16; i++) if (b[i]) last = i;
                if (g == 1 && b != 16'd0) last = 15;
                for (int i = 0; i <= last; i++) begin
                    if (b[i]) begin
                        push(g, n, FnADD, acc, mc);
                        s   = {1'b0, acc} + {1'b0, mc};
                        acc = s[15:0];
                        c   = c | s[16];
                    end
                    push(g, n, FnLSL, mc, 16'd0);
                    mc = mc << 1;
                end
                prod = {16'd0, a} * {16'd0, b};
                res  = prod[15:0];
            end
            default: ;
        endcase
        push(g, n, FnNOP, 16'd0, 16'd0);
        m_len[g]     = n;
        e_res[g]     = res;
        e_flg[g]     = 4'd0;
        e_flg[g][FZ] = (res == 16'd0);
        e_flg[g][FN] = res[15];
        e_flg[g][FC] = c;
    endtask

    // Compare the current cycle, then advance the model over the coming rising edge.
    initial forever begin
        @(negedge Clock);
        if (armed) begin
            for (int g = 0; g < 2; g++) begin
                check("busy", g, 32'(busy[g]), 32'(m_busy[g]));
                check("done", g, 32'(done[g]), 32'(m_done[g]));
                check("cin", g, 32'(cin[g]), 32'd0);
                if (m_busy[g]) begin
                    check("aluop", g, 32'(alu_op[g]), 32'(steps[g][m_pos[g]].op));
                    check("op1", g, 32'(op1[g]), 32'(steps[g][m_pos[g]].o1));
                    check("op2", g, 32'(op2[g]), 32'(steps[g][m_pos[g]].o2));
                end else begin
                    check("idle_op", g, {alu_op[g], op1[g], op2[g]}, {FnNOP, 16'd0, 16'd0});
                    check("result", g, 32'(result[g]), 32'(m_res[g]));
                    check("flags", g, 32'(flags[g]), 32'(m_flg[g]));
                end
            end
        end
        for (int g = 0; g < 2; g++) begin
            if (Reset) begin
                m_busy[g] = 0;
                m_done[g] = 0;
                m_res[g]  = 16'd0;
                m_flg[g]  = 4'd0;
            end else begin
                m_done[g] = 0;
                if (m_busy[g]) begin
                    m_pos[g]++;
                    if (m_pos[g] == m_len[g]) begin
                        m_busy[g] = 0;
                        m_done[g] = 1;
                        m_res[g]  = e_res[g];
                        m_flg[g]  = e_flg[g];
                    end
                end else if (Start) begin
                    build(g, SeqOp, A, B);
                    m_busy[g] = 1;
                    m_pos[g]  = 0;
                end
            end
        end
        if (Reset) armed = 1;
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Hand-computed latency/result/flags for instance g; poke holds Start high while busy.
    task automatic dir(input int g, input seq_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input int lat, input logic [15:0] res, input logic [3:0] flg,
                       input bit poke);
        int t = 0;
        while (m_busy[g] && t < 200) begin tick(); t++; end
        Start = 1'b1; SeqOp = op; A = a; B = b;
        tick();
        Start = poke; SeqOp = SEQ_SHL; A = 16'($urandom); B = 16'($urandom);
        t = 1;
        while (!done[g] && t < 60) begin
            tick();
            t++;
            if (t == 4) Start = 1'b0;
        end
        Start = 1'b0;
        check("latency", g, 32'(t), 32'(lat));
        check("lit_result", g, 32'(result[g]), 32'(res));
        check("lit_flags", g, 32'(flags[g]), 32'(flg));
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; SeqOp = SEQ_SHL; A = 16'd0; B = 16'd0;
        repeat (2) tick();
        Reset = 1'b0;
        check("rst_busy", 0, 32'(busy), 32'd0);
        check("rst_result", 0, 32'(result[0]), 32'd0);

        dir(0, SEQ_SHL, 16'h8001, 16'd1,      3, 16'h0002, 4'b0010, 0);
        dir(0, SEQ_SHR, 16'h0003, 16'd2,      4, 16'h0000, 4'b1010, 0);
        dir(0, SEQ_MUL, 16'd3,    16'd5,      7, 16'd15,   4'b0000, 0);
        dir(0, SEQ_MUL, 16'hFFFF, 16'hFFFF,  34, 16'h0001, 4'b0010, 1);
        dir(1, SEQ_MUL, 16'h1234, 16'd1,     19, 16'h1234, 4'b0000, 0);
        dir(0, SEQ_MUL, 16'hBEEF, 16'd0,      2, 16'h0000, 4'b1000, 0);
        dir(0, SEQ_SHL, 16'hABCD, 16'h0010,   2, 16'hABCD, 4'b0100, 0);
        dir(0, SEQ_RSV, 16'h5555, 16'h0003,   2, 16'h0000, 4'b1000, 0);

        // Abandon a long multiply with a reset.
        Start = 1'b1; SeqOp = SEQ_MUL; A = 16'hFFFF; B = 16'hFFFF;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_busy", 0, 32'(busy), 32'd0);
        check("midrst_done", 0, 32'(done), 32'd0);
        check("midrst_result", 0, 32'(result[0]), 32'd0);
        repeat (40) tick();

        for (int i = 0; i < 4000; i++) begin
            Start = ($urandom % 4 == 0);
            SeqOp = seq_op_t'(2'($urandom));
            A     = 16'($urandom);
            B     = ($urandom % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
            Reset = ($urandom % 500 == 0);
            tick();
        end
        Reset = 1'b0; Start = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
